// File: rtl/hjcnt_seg_scan.sv
// hjcnt_seg_scan: serial double-dabble BCD conversion of two 7-bit counts,
// time-multiplexed onto a six-digit common-anode 7-segment display.
module hjcnt_seg_scan #(
    parameter int SCAN_DIV = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] cnt,
    input  logic [6:0] cnt2,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       busy,
    output logic       bcd_valid
);
    localparam int SW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, CONV_A, CONV_B, COMMIT} state_t;
    state_t state, state_nx;

    logic [6:0] shadow_a, shadow_b;
    logic [2:0] bit_cnt;
    logic [11:0] bcd, bcd_nx, res_a, disp_a, disp_b, cur;
    logic [SW-1:0] scan_cnt;
    logic [2:0] dig_idx, pos;
    logic [3:0] nib;
    logic blank, src, last, change;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        change = {cnt, cnt2} != {shadow_a, shadow_b};
        last = bit_cnt == 3'd6;
        state_nx = state;
        case (state)
            IDLE:    state_nx = change ? CONV_A : IDLE;
            CONV_A:  state_nx = last ? CONV_B : CONV_A;
            CONV_B:  state_nx = last ? COMMIT : CONV_B;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = state != IDLE;

    // Hundreds never exceeds 1 for a 7-bit input, so only tens/units need the add-3 fixup
    always_comb begin
        src = state == CONV_A ? shadow_a[3'd6 - bit_cnt] : shadow_b[3'd6 - bit_cnt];
        bcd_nx = {bcd[10:8],
                  (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4],
                  (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0],
                  src};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_a  <= '0;
            shadow_b  <= '0;
            bit_cnt   <= '0;
            bcd       <= '0;
            res_a     <= '0;
            disp_a    <= '0;
            disp_b    <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= state == COMMIT;
            case (state)
                IDLE: if (change) begin
                    shadow_a <= cnt;
                    shadow_b <= cnt2;
                    bit_cnt  <= '0;
                    bcd      <= '0;
                end
                CONV_A, CONV_B: begin
                    bcd     <= bcd_nx;
                    bit_cnt <= last ? 3'd0 : bit_cnt + 3'd1;
                    if (last && state == CONV_A) begin
                        res_a <= bcd_nx;
                        bcd   <= '0;
                    end
                end
                default: begin
                    disp_a <= res_a;
                    disp_b <= bcd;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            dig_idx  <= dig_idx == 3'd5 ? 3'd0 : dig_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign an = ~(6'd1 << dig_idx);

    always_comb begin
        cur = dig_idx >= 3'd3 ? disp_b : disp_a;
        pos = dig_idx >= 3'd3 ? dig_idx - 3'd3 : dig_idx;
        nib = pos == 3'd0 ? cur[3:0] : pos == 3'd1 ? cur[7:4] : cur[11:8];
        blank = BLANK_LZ && (pos == 3'd2 ? cur[11:8] == 4'd0 : pos == 3'd1 && cur[11:4] == 8'd0);
        seg = 7'b1111111;
        if (!blank)
            case (nib)
                4'd0: seg = 7'b1000000;
                4'd1: seg = 7'b1111001;
                4'd2: seg = 7'b0100100;
                4'd3: seg = 7'b0110000;
                4'd4: seg = 7'b0011001;
                4'd5: seg = 7'b0010010;
                4'd6: seg = 7'b0000010;
                4'd7: seg = 7'b1111000;
                4'd8: seg = 7'b0000000;
                4'd9: seg = 7'b0010000;
                default: seg = 7'b1111111;
            endcase
    end
endmodule
